// File: rtl/cache_reg_arbiter.sv
// cache_reg_arbiter
//   Round-robin arbiter/controller that shares a bank of N_REGS cache
//   registers between N_REQ requesters. Transactions are serialised one per
//   cycle. The block drives the bank's one-hot store strobes and write data,
//   returns read data, and zero-fills the bank after reset or on clr.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        pulse, restarts the zero-init sequence
//   req        per-requester transaction request
//   we         per-requester write (1) / read (0)
//   addr       per-requester register address, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-hot, one-cycle grant
//   rdata      read data (holds between reads)
//   rvalid     one-cycle read-data-valid
//   rid        requester index owning rdata
//   err        one-cycle pulse when the granted address is >= N_REGS
//   busy       high while the bank is being zero-filled
//   reg_store  one-hot store strobe to the bank
//   reg_din    data_in shared by every bank register
//   reg_dout   data_out of every bank register, register j at [j*DATA_W +: DATA_W]
module cache_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_REGS = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic [$clog2(N_REQ)-1:0] rid,
  output logic                     err,
  output logic                     busy,
  output logic [N_REGS-1:0]        reg_store,
  output logic [DATA_W-1:0]        reg_din,
  input  logic [N_REGS*DATA_W-1:0] reg_dout
);

  localparam int RID_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(N_REGS);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [RID_W-1:0]   ptr, ptr_next;

  logic [N_REQ-1:0]   gnt_next;
  logic [DATA_W-1:0]  rdata_next;
  logic               rvalid_next;
  logic [RID_W-1:0]   rid_next;
  logic               err_next;
  logic               busy_next;
  logic [N_REGS-1:0]  store_next;
  logic [DATA_W-1:0]  din_next;

  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   upper;
  logic               found;
  logic               win_valid;
  logic [RID_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  win_addr;
  logic               win_we;
  logic [DATA_W-1:0]  win_wdata;
  logic               addr_ok;
  logic [CNT_W-1:0]   reg_sel;
  logic [DATA_W-1:0]  rd_data;

  // Round-robin pick. The requester granted this cycle is masked so a held
  // request cannot win back-to-back. Candidates at or above the pointer are
  // preferred; if none, the lowest eligible index wins (wrap-around).
  always_comb begin
    eligible  = req & ~gnt;
    upper     = '0;
    found     = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      upper[j] = eligible[j] && (j >= int'(ptr));
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (upper[j] && !found) begin
        win_idx = RID_W'(j);
        found   = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (eligible[j] && !found) begin
        win_idx = RID_W'(j);
        found   = 1'b1;
      end
    end
    win_valid = |eligible;
  end

  // Decode the winner's transaction. A read of a register whose store strobe
  // is active this cycle returns the data being written, because the bank
  // only captures it at the coming edge.
  always_comb begin
    win_addr  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_we    = we[win_idx];
    win_wdata = wdata[int'(win_idx)*DATA_W +: DATA_W];
    addr_ok   = int'(win_addr) < N_REGS;
    reg_sel   = addr_ok ? CNT_W'(win_addr) : '0;
    if (reg_store[reg_sel]) begin
      rd_data = reg_din;
    end else begin
      rd_data = reg_dout[int'(reg_sel)*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic. clr overrides everything, including a
  // grant that would otherwise be issued at this edge.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ptr_next    = ptr;
    gnt_next    = '0;
    store_next  = '0;
    rvalid_next = 1'b0;
    err_next    = 1'b0;
    busy_next   = busy;
    din_next    = reg_din;
    rdata_next  = rdata;
    rid_next    = rid;

    if (clr) begin
      state_next = INIT;
      cnt_next   = '0;
      busy_next  = 1'b1;
    end else begin
      case (state)
        INIT: begin
          busy_next  = 1'b1;
          store_next = N_REGS'(1) << cnt;
          din_next   = '0;
          if (cnt == CNT_W'(N_REGS - 1)) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        RUN: begin
          busy_next = 1'b0;
          if (win_valid) begin
            gnt_next = N_REQ'(1) << win_idx;
            ptr_next = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
            if (!addr_ok) begin
              err_next = 1'b1;
              if (!win_we) begin
                rvalid_next = 1'b1;
                rdata_next  = '0;
                rid_next    = win_idx;
              end
            end else if (win_we) begin
              store_next = N_REGS'(1) << reg_sel;
              din_next   = win_wdata;
            end else begin
              rvalid_next = 1'b1;
              rdata_next  = rd_data;
              rid_next    = win_idx;
            end
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      ptr       <= '0;
      gnt       <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      rid       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      reg_store <= '0;
      reg_din   <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ptr       <= ptr_next;
      gnt       <= gnt_next;
      rdata     <= rdata_next;
      rvalid    <= rvalid_next;
      rid       <= rid_next;
      err       <= err_next;
      busy      <= busy_next;
      reg_store <= store_next;
      reg_din   <= din_next;
    end
  end

endmodule

// File: tb/tb_cache_reg_arbiter.sv
// tb_cache_reg_arbiter
//   Self-checking bench for cache_reg_arbiter with a three-register bank, so
//   the out-of-range address path is reachable. A small register-bank model
//   answers reg_dout. A transaction-level reference model predicts every
//   output each cycle. Directed literal checks pin the model; randomized
//   requesters, clr pulses and one mid-run reset exercise the rest.
module tb_cache_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 3;
  localparam int AW    = 2;
  localparam int DW    = 16;
  localparam int RW    = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              clr   = 1'b0;
  logic [NREQ-1:0]   req   = '0;
  logic [NREQ-1:0]   we    = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [RW-1:0]     rid;
  logic              err;
  logic              busy;
  logic [NREGS-1:0]  reg_store;
  logic [DW-1:0]     reg_din;
  logic [NREGS*DW-1:0] reg_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_reg_arbiter #(
    .N_REQ (NREQ),
    .N_REGS(NREGS),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rid      (rid),
    .err      (err),
    .busy     (busy),
    .reg_store(reg_store),
    .reg_din  (reg_din),
    .reg_dout (reg_dout)
  );

  // Bank of cache registers, starting with garbage so zero-fill matters.
  logic [DW-1:0] bank [NREGS] = '{16'hA5A5, 16'h5A5A, 16'hC3C3};

  always @(posedge clk) begin
    for (int j = 0; j < NREGS; j++) begin
      if (reg_store[j]) bank[j] <= reg_din;
    end
  end

  always_comb begin
    reg_dout = '0;
    for (int j = 0; j < NREGS; j++) reg_dout[j*DW +: DW] = bank[j];
  end

  // Reference model: transaction-level view. Memory is updated the moment a
  // write is granted; reads return that memory.
  logic [NREQ-1:0]  exp_gnt    = '0;
  logic [NREGS-1:0] exp_store  = '0;
  logic [DW-1:0]    exp_din    = '0;
  logic [DW-1:0]    exp_rdata  = '0;
  logic             exp_rvalid = 1'b0;
  logic [RW-1:0]    exp_rid    = '0;
  logic             exp_err    = 1'b0;
  logic             exp_busy   = 1'b0;
  logic [DW-1:0]    m_mem [NREGS];
  int               m_ptr  = 0;
  int               m_init = 0;
  int               winner;
  int               cand;
  logic [NREQ-1:0]  prev_gnt;
  logic [AW-1:0]    m_addr;

  initial begin
    for (int j = 0; j < NREGS; j++) m_mem[j] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_gnt = '0; exp_store = '0; exp_din = '0; exp_rdata = '0;
        exp_rvalid = 1'b0; exp_rid = '0; exp_err = 1'b0; exp_busy = 1'b0;
        m_ptr = 0; m_init = 0;
      end else begin
        prev_gnt   = exp_gnt;
        exp_gnt    = '0;
        exp_store  = '0;
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
        if (clr) begin
          m_init   = 0;
          exp_busy = 1'b1;
        end else if (m_init < NREGS) begin
          exp_busy  = 1'b1;
          exp_store = NREGS'(1) << m_init;
          exp_din   = '0;
          m_mem[m_init] = '0;
          m_init++;
        end else begin
          exp_busy = 1'b0;
          winner   = -1;
          for (int k = 0; k < NREQ; k++) begin
            cand = (m_ptr + k) % NREQ;
            if (winner < 0 && req[cand] && !prev_gnt[cand]) winner = cand;
          end
          if (winner >= 0) begin
            exp_gnt = NREQ'(1) << winner;
            m_ptr   = (winner + 1) % NREQ;
            m_addr  = addr[winner*AW +: AW];
            if (int'(m_addr) >= NREGS) begin
              exp_err = 1'b1;
              if (!we[winner]) begin
                exp_rvalid = 1'b1;
                exp_rdata  = '0;
                exp_rid    = RW'(winner);
              end
            end else if (we[winner]) begin
              exp_store = NREGS'(1) << m_addr;
              exp_din   = wdata[winner*DW +: DW];
              m_mem[m_addr] = exp_din;
            end else begin
              exp_rvalid = 1'b1;
              exp_rdata  = m_mem[m_addr];
              exp_rid    = RW'(winner);
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = r;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic newTxn(input int i);
    applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                  DW'($urandom_range(0, 65535)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      checkOutput("gnt",       32'(gnt),       32'(exp_gnt));
      checkOutput("reg_store", 32'(reg_store), 32'(exp_store));
      checkOutput("reg_din",   32'(reg_din),   32'(exp_din));
      checkOutput("rdata",     32'(rdata),     32'(exp_rdata));
      checkOutput("rvalid",    32'(rvalid),    32'(exp_rvalid));
      checkOutput("rid",       32'(rid),       32'(exp_rid));
      checkOutput("err",       32'(err),       32'(exp_err));
      checkOutput("busy",      32'(busy),      32'(exp_busy));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_store", 32'(reg_store), 0);
    applyStimulus(0, 1'b1, 1'b1, 2'd2, 16'h1234);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-fill sequence, then the first write.
    tick();
    checkOutput("init0_busy",  32'(busy), 1);
    checkOutput("init0_store", 32'(reg_store), 32'b001);
    checkOutput("init0_din",   32'(reg_din), 0);
    checkOutput("init0_gnt",   32'(gnt), 0);
    tick();
    checkOutput("init1_store", 32'(reg_store), 32'b010);
    tick();
    checkOutput("init2_store", 32'(reg_store), 32'b100);
    checkOutput("init2_busy",  32'(busy), 1);
    tick();
    checkOutput("wr_busy",   32'(busy), 0);
    checkOutput("wr_gnt",    32'(gnt), 32'b0001);
    checkOutput("wr_store",  32'(reg_store), 32'b100);
    checkOutput("wr_din",    32'(reg_din), 32'h1234);
    checkOutput("wr_rvalid", 32'(rvalid), 0);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 16'h0);
    applyStimulus(1, 1'b1, 1'b1, 2'd1, 16'hBEEF);
    applyStimulus(2, 1'b1, 1'b0, 2'd1, 16'h0);

    // Write then read of the same register on consecutive grants.
    tick();
    checkOutput("wb_gnt",   32'(gnt), 32'b0010);
    checkOutput("wb_store", 32'(reg_store), 32'b010);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 16'h0);
    tick();
    checkOutput("byp_gnt",    32'(gnt), 32'b0100);
    checkOutput("byp_rvalid", 32'(rvalid), 1);
    checkOutput("byp_rdata",  32'(rdata), 32'hBEEF);
    checkOutput("byp_rid",    32'(rid), 2);
    applyStimulus(2, 1'b0, 1'b0, 2'd0, 16'h0);
    applyStimulus(3, 1'b1, 1'b0, 2'd3, 16'h0);

    // Out-of-range read.
    tick();
    checkOutput("oor_gnt",    32'(gnt), 32'b1000);
    checkOutput("oor_err",    32'(err), 1);
    checkOutput("oor_rvalid", 32'(rvalid), 1);
    checkOutput("oor_rdata",  32'(rdata), 0);
    checkOutput("oor_store",  32'(reg_store), 0);
    applyStimulus(0, 1'b1, 1'b0, 2'd0, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 2'd1, 16'h0);
    applyStimulus(2, 1'b1, 1'b0, 2'd2, 16'h0);
    applyStimulus(3, 1'b1, 1'b0, 2'd0, 16'h0);

    // Four contending reads rotate through every requester.
    tick();
    checkOutput("rr0_gnt", 32'(gnt), 32'b0001);
    checkOutput("rr0_rdata", 32'(rdata), 0);
    checkOutput("rr0_rid", 32'(rid), 0);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 16'h0);
    tick();
    checkOutput("rr1_gnt", 32'(gnt), 32'b0010);
    checkOutput("rr1_rdata", 32'(rdata), 32'hBEEF);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 16'h0);
    tick();
    checkOutput("rr2_gnt", 32'(gnt), 32'b0100);
    checkOutput("rr2_rdata", 32'(rdata), 32'h1234);
    applyStimulus(2, 1'b0, 1'b0, 2'd0, 16'h0);
    tick();
    checkOutput("rr3_gnt", 32'(gnt), 32'b1000);
    checkOutput("rr3_rid", 32'(rid), 3);
    applyStimulus(3, 1'b0, 1'b0, 2'd0, 16'h0);

    // clr while a write is pending: no grant until the bank is re-zeroed.
    applyStimulus(0, 1'b1, 1'b1, 2'd1, 16'h5555);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_gnt",  32'(gnt), 0);
    checkOutput("clr_busy", 32'(busy), 1);
    checkOutput("clr_store", 32'(reg_store), 0);
    for (int k = 0; k < NREGS; k++) begin
      tick();
      checkOutput("clr_init_gnt",   32'(gnt), 0);
      checkOutput("clr_init_store", 32'(reg_store), 32'(1 << k));
    end
    tick();
    checkOutput("resume_busy", 32'(busy), 0);
    checkOutput("resume_gnt",  32'(gnt), 32'b0001);
    checkOutput("resume_din",  32'(reg_din), 32'h5555);
    applyStimulus(0, 1'b0, 1'b0, 2'd0, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 2'd2, 16'h0);
    tick();
    checkOutput("rezero_rvalid", 32'(rvalid), 1);
    checkOutput("rezero_rdata",  32'(rdata), 0);
    applyStimulus(1, 1'b0, 1'b0, 2'd0, 16'h0);

    // Randomized requesters obeying the hold-until-grant contract.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #1 checkOutput("midrst_gnt", 32'(gnt), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      clr = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 1) newTxn(i);
          else applyStimulus(i, 1'b0, 1'b0, 2'd0, 16'h0);
        end else if (!req[i] && $urandom_range(0, 9) < 4) begin
          newTxn(i);
        end
      end
    end

    clr = 1'b0;
    req = '0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
